ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
Instruction-fetch front end that consumes the program counter and reads instructions from instruction memory. Issues one memory read per PC value and controls PC advance through the PC's enable. Pairs each in-order response with its address and presents it to decode over a valid/ready handshake. Sits between the pc block, instruction memory and the decode stage; discards stale fetches on a taken jump (flush).

Parameters:
FifoDepth, 2, entries in the instruction buffer; power of two, at least 2.
MaxOutstanding, 2, maximum memory reads in flight; at most FifoDepth.

Ports:
clk  in  1  system clock, rising edge
res  in  1  reset, synchronous, active-low
pc_in  in  32 (word)  current PC value from pc block
pc_enable  out  1  advance PC, wired to pc.enable
flush  in  1  taken jump/branch this cycle; pc block is in jump mode this cycle
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  read address, equals pc_in
mem_rsp_valid  in  1  read data valid; in order; no backpressure; latency at least 1 cycle
mem_rsp_data  in  32  read data
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_data  out  32  instruction word
inst_pc  out  32  address the instruction was fetched from

Behaviour:
- Reset: res sampled low at rising clk clears buffer, address queue, outstanding count and discard count. During reset and in the following cycle: inst_valid=0, mem_req_valid=0, pc_enable=0.
- Credit rule: mem_req_valid=1 when not in reset, flush=0, outstanding<MaxOutstanding and (outstanding + buffer count)<FifoDepth. Consequently a response always has buffer space.
- fire = mem_req_valid & mem_req_ready. On fire, push pc_in into the address queue and increment outstanding.
- pc_enable = fire | flush. The PC advances by INSTRUCTION_SIZE_IN_BYTES only on an accepted request. It is enabled during flush so the PC loads the jump target, because the PC ignores jumps while disabled.
- Response handling: on mem_rsp_valid, decrement outstanding and pop the address queue. If discard count>0, decrement it and drop the data. Otherwise push {data, address} into the buffer.
- Pass-through combinational paths: none. A response appears at inst_valid no earlier than 1 cycle after mem_rsp_valid. The minimum PC-to-decode latency is request cycle + memory latency + 1.
- Output: inst_valid = buffer not empty; inst_data and inst_pc are the buffer head. The head pops on inst_valid & inst_ready. Push and pop may occur in the same cycle, including when the buffer is full.
- Flush, effective next edge:
  - buffer is emptied, so inst_valid=0 in the next cycle;
  - discard count = outstanding minus any response arriving in the flush cycle, which is itself dropped;
  - address queue is emptied of those entries (outstanding is not zeroed; a discard is counted instead);
  - no request is issued in the flush cycle.
  The first request after flush uses the new pc_in (jump target).
- Flush and an inst_ready pop in the same cycle: flush wins; nothing is delivered twice.
- Back-to-back flushes: discard count recomputes each time and never goes negative.
- Reset overrides flush and all other events.
- Address arithmetic: 32-bit. pc_in wrap from 0xFFFF_FFFC to 0 needs no special handling. Low two address bits pass through unchanged.

Decomposition:
- Shared definitions header: word typedef, INSTRUCTION_SIZE_IN_BYTES, PC_INIT_ADDR, FETCH_FIFO_DEPTH default.
- One sub-module, fetch_fifo: synchronous FIFO, parameterised width and depth, with push, pop, clear, full, empty and count. Instantiate it twice: instruction buffer (64-bit {pc, data}) and address queue (32-bit, depth MaxOutstanding).

Test Plan:
- Reset, then memory always ready with 1-cycle latency, inst_ready=1 → inst_pc sequence PC_INIT_ADDR, +4, +8 … for 20 instructions with matching data; pc_enable pulses once per fire.
- inst_ready=0 for 10 cycles → exactly FifoDepth requests issued, then mem_req_valid=0 and pc_enable=0; PC frozen. Release → contents delivered in order, none lost.
- Flush with 2 requests in flight, jump target 0x0000_1000 → both stale responses dropped, inst_valid=0 next cycle, first delivered inst_pc=0x0000_1000.
- mem_req_ready toggling 1,0,0,1 with 3-cycle response latency → no duplicated or skipped address; outstanding never exceeds 2.
- res pulled low mid-stream with 2 in flight → next cycle inst_valid=0 and mem_req_valid=0; after release, delivery restarts at PC_INIT_ADDR with no stale data.
- Flush in the same cycle as a response and an inst_ready pop → that response dropped, no instruction delivered twice; pc_in=0xFFFF_FFFC fetch followed by 0x0000_0000.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: word type,
// fetch constants and the {pc, data} entry held by the instruction buffer.
package ifetch_unit_pkg;

  typedef logic [31:0] word_t;

  localparam word_t       INSTRUCTION_SIZE_IN_BYTES = 32'd4;
  localparam word_t       PC_INIT_ADDR              = 32'h0000_0000;
  localparam int unsigned FETCH_FIFO_DEPTH          = 2;

  typedef struct packed {
    word_t pc;
    word_t data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; push and pop may coincide, including when full.
// Clear and reset take priority over push/pop.
module fetch_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [Width-1:0]             data_i,
  output logic [Width-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) wr_d = ptr_inc(wr_q);
    if (do_pop)  rd_d = ptr_inc(rd_q);
    cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!res || clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (res && !clear_i && do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: credit-limited memory reads, in-order response
// pairing with the request address, and flush handling via a discard count.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned FifoDepth      = FETCH_FIFO_DEPTH,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic  clk,
  input  logic  res,
  input  word_t pc_in,
  output logic  pc_enable,
  input  logic  flush,
  output logic  mem_req_valid,
  input  logic  mem_req_ready,
  output word_t mem_req_addr,
  input  logic  mem_rsp_valid,
  input  word_t mem_rsp_data,
  output logic  inst_valid,
  input  logic  inst_ready,
  output word_t inst_data,
  output word_t inst_pc
);

  localparam int unsigned BufCntW = $clog2(FifoDepth + 1);
  localparam int unsigned AqCntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned SumW    = BufCntW + 1;

  logic                active_q;
  logic [AqCntW-1:0]   discard_q, discard_d;

  logic                fire, credit, rsp_keep;
  logic [SumW-1:0]     outstanding;

  logic                buf_push, buf_pop, buf_full, buf_empty;
  logic [BufCntW-1:0]  buf_count;
  fetch_entry_t        buf_in, buf_head;

  logic                aq_pop, aq_full, aq_empty;
  logic [AqCntW-1:0]   aq_count;
  word_t               aq_head;

  // Requests in flight = live addresses still queued + stale ones to be dropped.
  assign outstanding = SumW'(aq_count) + SumW'(discard_q);

  always_comb begin
    credit = (outstanding < SumW'(MaxOutstanding))
           && ((outstanding + SumW'(buf_count)) < SumW'(FifoDepth))
           && !aq_full;
    mem_req_valid = res & active_q & ~flush & credit;
    fire          = mem_req_valid & mem_req_ready;
    pc_enable     = res & active_q & (fire | flush);
    mem_req_addr  = pc_in;

    rsp_keep = mem_rsp_valid & (discard_q == '0);
    aq_pop   = rsp_keep & ~aq_empty;
    buf_push = rsp_keep & ~flush & (~buf_full | buf_pop);
    buf_in   = '{pc: aq_head, data: mem_rsp_data};

    inst_valid = res & ~buf_empty;
    buf_pop    = inst_valid & inst_ready;
    inst_data  = buf_head.data;
    inst_pc    = buf_head.pc;
  end

  // Stale addresses are never popped: clearing the queue on flush and counting
  // discards keeps later responses aligned with addresses pushed after the flush.
  always_comb begin
    discard_d = discard_q;
    if (flush) begin
      discard_d = AqCntW'(outstanding - SumW'(mem_rsp_valid));
    end else if (mem_rsp_valid && discard_q != '0) begin
      discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    active_q <= res;
    if (!res) begin
      discard_q <= '0;
    end else begin
      discard_q <= discard_d;
    end
  end

  fetch_fifo #(
    .Width ($bits(fetch_entry_t)),
    .Depth (FifoDepth)
  ) u_inst_buf (
    .clk     (clk),
    .res     (res),
    .clear_i (flush),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .data_i  (buf_in),
    .data_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  fetch_fifo #(
    .Width ($bits(word_t)),
    .Depth (MaxOutstanding)
  ) u_addr_q (
    .clk     (clk),
    .res     (res),
    .clear_i (flush),
    .push_i  (fire),
    .pop_i   (aq_pop),
    .data_i  (pc_in),
    .data_o  (aq_head),
    .full_o  (aq_full),
    .empty_o (aq_empty),
    .count_o (aq_count)
  );

endmodule
